// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding, datapath widths and the
// opcode table used by the control decoder, the fetch stage and the benches.
// No ports (package).
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    localparam int INSTR_W = 9;
    localparam int ACC_W   = 8;

    localparam logic [4:0] OP_BEQ  = 5'd22;
    localparam logic [4:0] OP_RB   = 5'd23;
    localparam logic [4:0] OP_AB   = 5'd24;
    localparam logic [4:0] OP_DONE = 5'd31;

endpackage : cpu_pkg

// File: rtl/jump_lut.sv
// Absolute-jump target table, read combinationally.
// Contents are fixed at elaboration and taken from a built-in table.
// Ports:
//   idx    in  LUT_AW  table index
//   target out PC_W    jump target for that index
module jump_lut #(
    parameter int    LUT_AW   = 4,
    parameter int    PC_W     = 10,
    parameter string LUT_FILE = "jump_lut.hex"
) (
    input  logic [LUT_AW-1:0] idx,
    output logic [PC_W-1:0]   target
);

    localparam int LUT_DEPTH = 2 ** LUT_AW;

    logic [PC_W-1:0] lut_mem_s [0:LUT_DEPTH-1];

    // Built-in table; entry 3 and the last entry are deliberate landmarks
    // (mid-program target and last legal word of a 1K program).
    function automatic logic [PC_W-1:0] default_entry(input int unsigned i);
        logic [PC_W-1:0] v;
        case (i)
            32'd3:  v = PC_W'(12'h120);
            32'd15: v = PC_W'(12'h3FF);
            default: v = PC_W'(i * 32'd64);
        endcase
        return v;
    endfunction

    for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_entry
        assign lut_mem_s[g] = default_entry(g);
    end

    assign target = lut_mem_s[idx];

endmodule : jump_lut

// File: rtl/fetch_unit.sv
// Program counter / instruction fetch stage.
// Holds the PC (driven straight onto imem_addr), computes the next PC from the
// control decoder's enables, and parks in FAULT on an out-of-range target.
// Optional statistics counters are built when FETCH_STATS_EN is defined.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   pc_reset                   synchronous restart (highest priority)
//   pc_enable                  advance PC this cycle
//   reljump_enable             relative branch (signed acc_value offset)
//   absjump_enable             absolute branch via LUT[acc_value[LUT_AW-1:0]]
//   compare_enable, cmp_flag   conditional branch qualifier
//   acc_value [7:0]            accumulator
//   imem_addr [PC_W-1:0]       current PC
//   branch_taken               registered one-cycle pulse after a taken branch
//   pc_fault                   sticky out-of-range flag
//   instr_count [31:0]         (FETCH_STATS_EN) non-faulting advances
//   taken_count [15:0]         (FETCH_STATS_EN) taken branches
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int    PC_W       = 10,
    parameter int    PROG_DEPTH = 1024,
    parameter int    START_ADDR = 0,
    parameter int    LUT_AW     = 4,
    parameter string LUT_FILE   = "jump_lut.hex"
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pc_reset,
    input  logic             pc_enable,
    input  logic             reljump_enable,
    input  logic             absjump_enable,
    input  logic             compare_enable,
    input  logic             cmp_flag,
    input  logic [ACC_W-1:0] acc_value,
    output logic [PC_W-1:0]  imem_addr,
    output logic             branch_taken,
    output logic             pc_fault
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]      instr_count,
    output logic [15:0]      taken_count
`endif
);

    // One extra bit so negative and >= 2**PC_W candidates are both visible.
    localparam int            CW       = PC_W + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(PROG_DEPTH);
    localparam logic [PC_W-1:0] START_C = PC_W'(START_ADDR);

    fetch_state_t    state_r, next_state_s;
    logic [PC_W-1:0] pc_r, pc_next_s;
    logic            branch_taken_r, bt_next_s;
    logic            pc_fault_r, fault_next_s;

    logic [PC_W-1:0] lut_target_s;
    logic [CW-1:0]   rel_off_s;
    logic [CW-1:0]   cand_s;
    logic            rel_taken_s;
    logic            branch_s;
    logic            out_of_range_s;
    logic            advance_s;

    jump_lut #(
        .LUT_AW   (LUT_AW),
        .PC_W     (PC_W),
        .LUT_FILE (LUT_FILE)
    ) u_jump_lut (
        .idx    (acc_value[LUT_AW-1:0]),
        .target (lut_target_s)
    );

    assign rel_off_s   = {{(CW-ACC_W){acc_value[ACC_W-1]}}, acc_value};
    assign rel_taken_s = reljump_enable & (~compare_enable | cmp_flag);
    assign branch_s    = absjump_enable | rel_taken_s;
    assign advance_s   = (state_r == RUN) & pc_enable & ~pc_reset;

    // Candidate next PC by priority: absolute, taken relative, sequential.
    always_comb begin
        cand_s = {1'b0, pc_r} + CW'(1'b1);
        if (absjump_enable) begin
            cand_s = {1'b0, lut_target_s};
        end else if (rel_taken_s) begin
            cand_s = {1'b0, pc_r} + rel_off_s;
        end else begin
            cand_s = {1'b0, pc_r} + CW'(1'b1);
        end
    end

    // A set top bit means negative (or overflowed past 2**PC_W); either way
    // the unsigned compare against the depth catches it.
    assign out_of_range_s = (cand_s >= DEPTH_C);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        if (pc_reset) begin
            next_state_s = RUN;
        end else begin
            case (state_r)
                IDLE:    next_state_s = IDLE;
                RUN:     next_state_s = (pc_enable && out_of_range_s) ? FAULT : RUN;
                FAULT:   next_state_s = FAULT;
                default: next_state_s = FAULT;
            endcase
        end
    end

    // FSM output logic: next PC, branch pulse and fault flag.
    always_comb begin
        pc_next_s    = pc_r;
        bt_next_s    = 1'b0;
        fault_next_s = pc_fault_r;
        if (pc_reset) begin
            pc_next_s    = START_C;
            fault_next_s = 1'b0;
        end else if (advance_s) begin
            if (out_of_range_s) begin
                fault_next_s = 1'b1;
            end else begin
                pc_next_s = cand_s[PC_W-1:0];
                bt_next_s = branch_s;
            end
        end else begin
            pc_next_s = pc_r;
        end
    end

    // PC and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r           <= '0;
            branch_taken_r <= 1'b0;
            pc_fault_r     <= 1'b0;
        end else begin
            pc_r           <= pc_next_s;
            branch_taken_r <= bt_next_s;
            pc_fault_r     <= fault_next_s;
        end
    end

    assign imem_addr    = pc_r;
    assign branch_taken = branch_taken_r;
    assign pc_fault     = pc_fault_r;

`ifdef FETCH_STATS_EN
    logic [31:0] instr_count_r;
    logic [15:0] taken_count_r;

    // Saturating statistics counters; cleared on restart, frozen in FAULT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count_r <= 32'd0;
            taken_count_r <= 16'd0;
        end else if (pc_reset) begin
            instr_count_r <= 32'd0;
            taken_count_r <= 16'd0;
        end else begin
            if (advance_s && !out_of_range_s && (instr_count_r != 32'hFFFF_FFFF)) begin
                instr_count_r <= instr_count_r + 32'd1;
            end
            if (bt_next_s && (taken_count_r != 16'hFFFF)) begin
                taken_count_r <= taken_count_r + 16'd1;
            end
        end
    end

    assign instr_count = instr_count_r;
    assign taken_count = taken_count_r;
`endif

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: each stimulus step pushes the expected
// post-edge state; a monitor pops and compares after every rising edge.
// Uses the built-in jump table (LUT_FILE empty): LUT[3]=0x120, LUT[15]=0x3FF.
module tb_fetch_unit;
    import cpu_pkg::*;

    typedef struct {
        logic [9:0] pc;
        logic       bt;
        logic       fault;
        string      name;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       pc_reset;
    logic       pc_enable;
    logic       reljump_enable;
    logic       absjump_enable;
    logic       compare_enable;
    logic       cmp_flag;
    logic [7:0] acc_value;
    logic [9:0] imem_addr;
    logic       branch_taken;
    logic       pc_fault;
`ifdef FETCH_STATS_EN
    logic [31:0] instr_count;
    logic [15:0] taken_count;
`endif

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    fetch_unit #(
        .PC_W       (10),
        .PROG_DEPTH (1024),
        .START_ADDR (0),
        .LUT_AW     (4),
        .LUT_FILE   ("")
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_reset       (pc_reset),
        .pc_enable      (pc_enable),
        .reljump_enable (reljump_enable),
        .absjump_enable (absjump_enable),
        .compare_enable (compare_enable),
        .cmp_flag       (cmp_flag),
        .acc_value      (acc_value),
        .imem_addr      (imem_addr),
        .branch_taken   (branch_taken),
        .pc_fault       (pc_fault)
`ifdef FETCH_STATS_EN
        ,
        .instr_count    (instr_count),
        .taken_count    (taken_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_now(input string name, input logic [9:0] pc,
                             input logic bt, input logic fault);
        n_checks++;
        if (imem_addr !== pc || branch_taken !== bt || pc_fault !== fault) begin
            n_fail++;
            $display("FAIL %s: got pc=%h bt=%b fault=%b, expected pc=%h bt=%b fault=%b",
                     name, imem_addr, branch_taken, pc_fault, pc, bt, fault);
        end
    endtask

    // Monitor: compare the DUT against the oldest expectation after each edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_now(e.name, e.pc, e.bt, e.fault);
        end
    end

    task automatic step(input string name, input logic rst, input logic en,
                        input logic rel, input logic abs_j, input logic cmpen,
                        input logic flag, input logic [7:0] acc,
                        input logic [9:0] e_pc, input logic e_bt, input logic e_f);
        exp_t e;
        @(negedge clk);
        pc_reset       = rst;
        pc_enable      = en;
        reljump_enable = rel;
        absjump_enable = abs_j;
        compare_enable = cmpen;
        cmp_flag       = flag;
        acc_value      = acc;
        e.pc = e_pc; e.bt = e_bt; e.fault = e_f; e.name = name;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        pc_reset = 1'b0; pc_enable = 1'b1; reljump_enable = 1'b0;
        absjump_enable = 1'b0; compare_enable = 1'b0; cmp_flag = 1'b0;
        acc_value = 8'h00;
        #22;
        check_now("reset_state", 10'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        //   name            rst  en   rel  abs  cmp  flg  acc     pc       bt   f
        step("idle_hold",    1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 10'd0,   1'b0,1'b0);
        step("restart",      1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,8'h05, 10'd0,   1'b0,1'b0);
        for (int i = 1; i <= 5; i++)
            step("seq_adv",  1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 10'(i),  1'b0,1'b0);
        step("rel_to_10",    1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,8'h05, 10'd10,  1'b1,1'b0);
        step("en_low_hold",  1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,8'h03, 10'd10,  1'b0,1'b0);
        step("beq_taken",    1'b0,1'b1,1'b1,1'b0,1'b1,1'b1,8'hFC, 10'd6,   1'b1,1'b0);
        step("pulse_end",    1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 10'd7,   1'b0,1'b0);
        step("rel_back_10",  1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,8'h03, 10'd10,  1'b1,1'b0);
        step("beq_not_taken",1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,8'hFC, 10'd11,  1'b0,1'b0);
        step("abs_over_rel", 1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,8'h03, 10'h120, 1'b1,1'b0);
        step("abs_to_top",   1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,8'h0F, 10'h3FF, 1'b1,1'b0);
        step("top_fault",    1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 10'h3FF, 1'b0,1'b1);
        step("fault_seq",    1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 10'h3FF, 1'b0,1'b1);
        step("fault_abs",    1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,8'h03, 10'h3FF, 1'b0,1'b1);
        step("fault_exit",   1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 10'd0,   1'b0,1'b0);
        step("seq_1",        1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 10'd1,   1'b0,1'b0);
        step("seq_2",        1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 10'd2,   1'b0,1'b0);
        step("neg_fault",    1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,8'hF0, 10'd2,   1'b0,1'b1);
        step("neg_restart",  1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 10'd0,   1'b0,1'b0);
        step("abs_idx_mask", 1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,8'hF3, 10'h120, 1'b1,1'b0);
        step("restart_2",    1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 10'd0,   1'b0,1'b0);
        step("rel_to_55",    1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,8'h55, 10'h055, 1'b1,1'b0);
        step("seq_56",       1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 10'h056, 1'b0,1'b0);

        // Asynchronous reset between edges must clear the PC immediately.
        #3;
        rst_n = 1'b0;
        #1;
        check_now("async_reset", 10'd0, 1'b0, 1'b0);
`ifdef FETCH_STATS_EN
        n_checks++;
        if (instr_count !== 32'd0) begin
            n_fail++;
            $display("FAIL async_instr_count: got %0d expected 0", instr_count);
        end
`endif
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_unit
